// File: rtl/ysyx_22041207_axi_rd_master.sv
// Single-beat AXI4 read master: takes one aligned read request, issues AR, captures one R beat,
// and returns the extracted, zero-extended data with its response.
module ysyx_22041207_axi_rd_master #(
  parameter int unsigned RW_DATA_WIDTH  = 64,
  parameter int unsigned RW_ADDR_WIDTH  = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rw_valid_i,
  output logic                      rw_ready_o,
  input  logic [RW_ADDR_WIDTH-1:0]  rw_addr_i,
  input  logic [7:0]                rw_size_i,
  output logic [RW_DATA_WIDTH-1:0]  data_read_o,
  output logic                      data_valid_o,
  input  logic                      data_ready_i,
  output logic [1:0]                resp_o,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   ar_id_o,
  output logic [7:0]                ar_len_o,
  output logic [2:0]                ar_size_o,
  output logic [1:0]                ar_burst_o,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic                      r_last_i
);

  localparam int unsigned SizeW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [RW_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [SizeW-1:0]          size_q, size_d;
  logic [RW_DATA_WIDTH-1:0]  data_q, data_d;
  logic [1:0]                resp_q, resp_d;
  logic [AXI_DATA_WIDTH-1:0] beat_shifted;
  logic [RW_DATA_WIDTH-1:0]  beat_mask;

  // Move the addressed byte lane down to bit 0.
  assign beat_shifted = r_data_i >> {addr_q[2:0], 3'b000};

  // Expand the byte-enable style size into a bit mask, one byte per size bit.
  always_comb begin
    beat_mask = '0;
    for (int unsigned i = 0; i < RW_DATA_WIDTH; i++) begin
      if (i < SizeW * 8) beat_mask[i] = size_q[3'(i / 8)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    data_d  = data_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: begin
        if (rw_valid_i) begin
          addr_d  = rw_addr_i;
          size_d  = rw_size_i;
          state_d = AR;
        end
      end
      AR: begin
        if (ar_ready_i) state_d = R;
      end
      R: begin
        if (r_valid_i) begin
          data_d  = RW_DATA_WIDTH'(beat_shifted) & beat_mask;
          // A single-beat read must end with RLAST; anything else is a slave protocol error.
          resp_d  = r_last_i ? r_resp_i : 2'b10;
          state_d = DONE;
        end
      end
      DONE: begin
        if (data_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (size_q)
      8'h01:   ar_size_o = 3'd0;
      8'h03:   ar_size_o = 3'd1;
      8'h0F:   ar_size_o = 3'd2;
      default: ar_size_o = 3'd3;
    endcase
  end

  assign rw_ready_o   = (state_q == IDLE);
  assign ar_valid_o   = (state_q == AR);
  assign r_ready_o    = (state_q == R);
  assign data_valid_o = (state_q == DONE);
  assign ar_addr_o    = AXI_ADDR_WIDTH'(addr_q);
  assign ar_id_o      = '0;
  assign ar_len_o     = 8'd0;
  assign ar_burst_o   = 2'b01;
  assign data_read_o  = data_q;
  assign resp_o       = resp_q;

endmodule

// File: tb/tb_ysyx_22041207_axi_rd_master.sv
// Directed and randomized bench for the single-beat AXI read master, checked against
// an arithmetic model of the expected AR fields, extracted data and response.
module tb_ysyx_22041207_axi_rd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rw_valid;
  logic        rw_ready;
  logic [63:0] rw_addr;
  logic [7:0]  rw_size;
  logic [63:0] data_read;
  logic        data_valid;
  logic        data_ready;
  logic [1:0]  resp;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22041207_axi_rd_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rw_valid_i   (rw_valid),
    .rw_ready_o   (rw_ready),
    .rw_addr_i    (rw_addr),
    .rw_size_i    (rw_size),
    .data_read_o  (data_read),
    .data_valid_o (data_valid),
    .data_ready_i (data_ready),
    .resp_o       (resp),
    .ar_valid_o   (ar_valid),
    .ar_ready_i   (ar_ready),
    .ar_addr_o    (ar_addr),
    .ar_id_o      (ar_id),
    .ar_len_o     (ar_len),
    .ar_size_o    (ar_size),
    .ar_burst_o   (ar_burst),
    .r_valid_i    (r_valid),
    .r_ready_o    (r_ready),
    .r_data_i     (r_data),
    .r_resp_i     (r_resp),
    .r_last_i     (r_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int nbytes(input logic [7:0] sz);
    case (sz)
      8'h01:   return 1;
      8'h03:   return 2;
      8'h0F:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] model_data(input logic [63:0] a, input logic [7:0] sz,
                                             input logic [63:0] d);
    logic [63:0] shifted;
    logic [63:0] mask;
    shifted = d >> (8 * int'(a % 8));
    mask = (nbytes(sz) == 8) ? '1 : ((64'd1 << (8 * nbytes(sz))) - 64'd1);
    return shifted & mask;
  endfunction

  function automatic logic [2:0] model_size(input logic [7:0] sz);
    return 3'($clog2(nbytes(sz)));
  endfunction

  // One complete transaction with configurable AR wait, R wait and consumer stall.
  task automatic txn(input logic [63:0] a, input logic [7:0] sz, input logic [63:0] d,
                     input logic [1:0] rr, input logic rl,
                     input int ard, input int rd, input int dd);
    logic [63:0] exp_d;
    logic [1:0]  exp_r;
    exp_d = model_data(a, sz, d);
    exp_r = rl ? rr : 2'b10;
    chk("idle_rw_ready", 64'(rw_ready), 64'd1);
    rw_valid = 1'b1; rw_addr = a; rw_size = sz;
    tick();
    rw_valid = 1'b0; rw_addr = {$urandom, $urandom}; rw_size = 8'($urandom);
    // Decoy beat present during AR must not be captured.
    r_valid = 1'b1; r_data = ~d; r_resp = 2'b01; r_last = 1'b1;
    chk("ar_id", 64'(ar_id), 64'd0);
    chk("ar_len", 64'(ar_len), 64'd0);
    chk("ar_burst", 64'(ar_burst), 64'd1);
    for (int i = 0; i <= ard; i++) begin
      chk("ar_valid", 64'(ar_valid), 64'd1);
      chk("ar_addr", ar_addr, a);
      chk("ar_size", 64'(ar_size), 64'(model_size(sz)));
      chk("ar_rw_ready", 64'(rw_ready), 64'd0);
      chk("ar_r_ready", 64'(r_ready), 64'd0);
      ar_ready = (i == ard);
      tick();
    end
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    for (int i = 0; i <= rd; i++) begin
      chk("r_ready", 64'(r_ready), 64'd1);
      chk("r_ar_valid", 64'(ar_valid), 64'd0);
      chk("r_data_valid", 64'(data_valid), 64'd0);
      if (i == rd) begin
        r_valid = 1'b1; r_data = d; r_resp = rr; r_last = rl;
      end
      tick();
    end
    r_valid = 1'b1; r_data = ~d; r_resp = 2'b01; r_last = 1'b1;
    for (int i = 0; i <= dd; i++) begin
      chk("done_valid", 64'(data_valid), 64'd1);
      chk("done_data", data_read, exp_d);
      chk("done_resp", 64'(resp), 64'(exp_r));
      chk("done_rw_ready", 64'(rw_ready), 64'd0);
      chk("done_r_ready", 64'(r_ready), 64'd0);
      data_ready = (i == dd);
      tick();
    end
    data_ready = 1'b0;
    r_valid    = 1'b0;
    chk("back_idle", 64'(rw_ready), 64'd1);
    chk("back_idle_dv", 64'(data_valid), 64'd0);
  endtask

  initial begin
    logic [7:0]  sizes [4];
    logic [63:0] a;
    logic [63:0] d;
    sizes[0] = 8'h01; sizes[1] = 8'h03; sizes[2] = 8'h0F; sizes[3] = 8'hFF;

    rst_n = 1'b0; rw_valid = 1'b0; rw_addr = '0; rw_size = '0; data_ready = 1'b0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0;
    #12;
    chk("rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("rst_r_ready", 64'(r_ready), 64'd0);
    chk("rst_data_valid", 64'(data_valid), 64'd0);
    chk("rst_data_read", data_read, 64'd0);
    chk("rst_resp", 64'(resp), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rw_ready", 64'(rw_ready), 64'd1);

    // Dword and byte reads at minimum latency.
    txn(64'h8000_0000, 8'hFF, 64'h1122334455667788, 2'b00, 1'b1, 0, 0, 0);
    txn(64'h8000_0005, 8'h01, 64'h1122334455667788, 2'b00, 1'b1, 0, 0, 0);
    // AR backpressure then consumer stall.
    txn(64'h8000_0002, 8'h03, 64'hCAFE_F00D_DEAD_BEEF, 2'b00, 1'b1, 5, 0, 3);
    // Error responses.
    txn(64'h0000_1004, 8'h0F, 64'hA5A5_5A5A_0123_4567, 2'b11, 1'b1, 0, 2, 0);
    txn(64'h0000_1000, 8'hFF, 64'h0F0F_F0F0_1234_5678, 2'b00, 1'b0, 1, 1, 1);

    // Reset asserted while waiting in R.
    rw_valid = 1'b1; rw_addr = 64'h40; rw_size = 8'hFF;
    tick();
    rw_valid = 1'b0; ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    chk("pre_rst_r_ready", 64'(r_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midr_rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("midr_rst_r_ready", 64'(r_ready), 64'd0);
    chk("midr_rst_data_valid", 64'(data_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midr_rel_rw_ready", 64'(rw_ready), 64'd1);
    tick();
    txn(64'h0000_0048, 8'h0F, 64'h1357_9BDF_2468_ACE0, 2'b00, 1'b1, 0, 0, 0);

    // Back-to-back with rw_valid held high.
    rw_valid = 1'b1; rw_addr = 64'h0; rw_size = 8'hFF;
    ar_ready = 1'b1; r_valid = 1'b1; r_data = 64'h0101_0202_0303_0404; r_resp = 2'b00; r_last = 1'b1;
    tick();
    rw_addr = 64'h8;
    chk("b2b_ar0", ar_addr, 64'h0);
    tick();
    tick();
    chk("b2b_dv0", 64'(data_valid), 64'd1);
    chk("b2b_data0", data_read, 64'h0101_0202_0303_0404);
    chk("b2b_rw_ready_done", 64'(rw_ready), 64'd0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    r_data = 64'h0505_0606_0707_0808;
    chk("b2b_idle_gap", 64'(rw_ready), 64'd1);
    chk("b2b_idle_no_ar", 64'(ar_valid), 64'd0);
    tick();
    rw_valid = 1'b0;
    chk("b2b_ar1", ar_addr, 64'h8);
    chk("b2b_ar1_valid", 64'(ar_valid), 64'd1);
    tick();
    tick();
    chk("b2b_data1", data_read, 64'h0505_0606_0707_0808);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0; ar_ready = 1'b0; r_valid = 1'b0;
    chk("b2b_end_idle", 64'(rw_ready), 64'd1);

    // Randomized transactions.
    for (int n = 0; n < 30; n++) begin
      a = {$urandom, $urandom};
      d = {$urandom, $urandom};
      txn(a, sizes[$urandom_range(0, 3)], d, 2'($urandom), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_axi_rd_master.md
YSYX_22041207_AXI_RD_MASTER -- requirements
Module: ysyx_22041207_axi_rd_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- RW_DATA_WIDTH, 64, request-side data width.
- RW_ADDR_WIDTH, 64, request-side address width.
- AXI_DATA_WIDTH, 64, R beat width.
- AXI_ADDR_WIDTH, 64, AR address width.
- AXI_ID_WIDTH, 4, ID width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- rw_valid_i  in  1  read request from arbiter.
- rw_ready_o  out  1  request accepted.
- rw_addr_i  in  RW_ADDR_WIDTH  byte address.
- rw_size_i  in  8  byte mask: 8'h01 = byte, 8'h03 = half, 8'h0F = word, 8'hFF = dword.
- data_read_o  out  RW_DATA_WIDTH  aligned, zero-extended read data.
- data_valid_o  out  1  data_read_o/resp_o valid.
- data_ready_i  in  1  consumer takes data.
- resp_o  out  2  captured RRESP, forced to 2'b10 on protocol error.
- ar_valid_o  out  1  AXI ARVALID.
- ar_ready_i  in  1  AXI ARREADY.
- ar_addr_o  out  AXI_ADDR_WIDTH  AXI ARADDR.
- ar_id_o  out  AXI_ID_WIDTH  AXI ARID.
- ar_len_o  out  8  AXI ARLEN.
- ar_size_o  out  3  AXI ARSIZE.
- ar_burst_o  out  2  AXI ARBURST.
- r_valid_i  in  1  AXI RVALID.
- r_ready_o  out  1  AXI RREADY.
- r_data_i  in  AXI_DATA_WIDTH  AXI RDATA.
- r_resp_i  in  2  AXI RRESP.
- r_last_i  in  1  AXI RLAST.

Function
REQ-004 The FSM SHALL have exactly four states, IDLE, AR, R and DONE, encoded in 2 bits, with reset state IDLE.
REQ-005 rw_ready_o SHALL be 1 iff the state is IDLE.
REQ-006 In IDLE, rw_valid_i=1 SHALL latch rw_addr_i and rw_size_i and move to AR on the next edge; otherwise the FSM stays in IDLE.
REQ-007 ar_valid_o SHALL be 1 iff the state is AR.
REQ-008 While ar_valid_o=1, ar_addr_o SHALL equal the latched address and SHALL stay stable until ar_ready_i=1.
REQ-009 ar_id_o SHALL be 0, ar_len_o SHALL be 0 (single beat), and ar_burst_o SHALL be 2'b01 (INCR) at all times.
REQ-010 ar_size_o SHALL map the latched size: 8'h01 -> 0, 8'h03 -> 1, 8'h0F -> 2, 8'hFF -> 3, any other value -> 3.
REQ-011 In AR, ar_ready_i=1 SHALL move the FSM to R; otherwise ar_valid_o is held.
REQ-012 r_ready_o SHALL be 1 iff the state is R.
REQ-013 In R, r_valid_i=1 SHALL capture the beat and move the FSM to DONE.
REQ-014 The captured resp_o SHALL be r_resp_i when r_last_i=1, and 2'b10 (SLVERR) when r_last_i=0.
REQ-015 The data capture SHALL compute data_read_o = (r_data_i >> (8*addr[2:0])) & zero-extended size mask.
REQ-016 R beats arriving outside state R SHALL be ignored, since r_ready_o=0.
REQ-017 data_valid_o SHALL be 1 iff the state is DONE.
REQ-018 data_read_o and resp_o SHALL be registered and SHALL hold stable throughout DONE.
REQ-019 In DONE, data_ready_i=1 SHALL return the FSM to IDLE; otherwise it stays in DONE.
REQ-020 A new request SHALL NOT be accepted before the cycle after the DONE handshake, since rw_ready_o=0 outside IDLE.
REQ-021 Minimum latency with ar_ready_i=1 and r_valid_i=1 already asserted SHALL be: request accepted at edge 0, AR handshake at edge 1, R capture at edge 2, data_valid_o=1 during cycle 3.
REQ-022 Changes on rw_addr_i and rw_size_i after acceptance SHALL have no effect on the transaction in flight.
REQ-023 If ar_ready_i and r_valid_i are both high in the AR cycle, the R beat SHALL NOT be taken in that cycle; capture occurs in R.

Reset
REQ-024 rst_n=0 SHALL, asynchronously and in any state (including mid-AR or mid-R), force state IDLE.
REQ-025 The same reset SHALL force ar_valid_o=0, r_ready_o=0, data_valid_o=0, data_read_o=0 and resp_o=0.
REQ-026 rw_ready_o SHALL be 1 from the first cycle after rst_n rises.

Verification
REQ-027 Dword read: addr 0x8000_0000, size 8'hFF, ar_ready_i=1, r_data_i=0x1122334455667788, resp 0, last 1 -> ar_size_o=3; data_read_o=0x1122334455667788 and data_valid_o=1 during cycle 3.
REQ-028 Byte read: addr 0x8000_0005, size 8'h01, r_data_i=0x1122334455667788 -> ar_size_o=0, ar_addr_o=0x8000_0005, data_read_o=0x0000000000000033.
REQ-029 Backpressure: ar_ready_i held 0 for 5 cycles -> ar_valid_o and ar_addr_o stable for 5 cycles. Then data_ready_i held 0 for 3 cycles -> data_valid_o and data_read_o stable, FSM stays in DONE.
REQ-030 Error: r_resp_i=2'b11, r_last_i=1 -> resp_o=2'b11. Separately, r_last_i=0 -> resp_o=2'b10.
REQ-031 Reset in R state: assert rst_n=0 -> next sample shows ar_valid_o=0, r_ready_o=0, data_valid_o=0. After release, rw_ready_o=1 and a new request completes normally.
REQ-032 Back-to-back: two requests (addr 0x0 and 0x8, rw_valid_i held high) -> second accepted only in the IDLE cycle after the first DONE handshake, and both data words are correct.
